// File: rtl/bf_multiplier_pipe.sv
// bf_multiplier_pipe: LANES-wide pipelined floating-point multiplier
// (unpack/multiply, normalise, round/pack) with valid/ready flow control.
module bf_multiplier_pipe #(
  parameter int EXP_W      = 8,
  parameter int MAN_W      = 7,
  parameter int LANES      = 4,
  parameter int ROUND_MODE = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [LANES*(1+EXP_W+MAN_W)-1:0] num1,
  input  logic [LANES*(1+EXP_W+MAN_W)-1:0] num2,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [LANES*(1+EXP_W+MAN_W)-1:0] mul,
  output logic [LANES*4-1:0]               flags
);
  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int BIAS = 2**(EXP_W-1) - 1;
  localparam int SW   = MAN_W + 1;
  localparam int PW   = 2 * SW;
  localparam int EW   = SW + 2;
  localparam int XW   = EXP_W + 2;
  localparam int LW   = $clog2(PW + 1);
  localparam int EMAX = 2**EXP_W - 1;

  logic v1, v2, v3, adv;

  assign adv       = !v3 | out_ready;
  assign in_ready  = adv;
  assign out_valid = v3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else if (adv) begin
      v1 <= in_valid;
      v2 <= v1;
      v3 <= v2;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [W-1:0]         a, b;
    logic [EXP_W-1:0]     ea, eb, xa, xb;
    logic [MAN_W-1:0]     fa, fb;
    logic                 za, zb, ia, ib, na, nb, sgn;
    logic [SW-1:0]        ma, mb;
    logic signed [XW-1:0] es;
    logic [PW-1:0]        prod;
    logic                 sp_c, nv_c;
    logic [W-1:0]         sv_c;

    assign a    = num1[i*W +: W];
    assign b    = num2[i*W +: W];
    assign ea   = a[W-2 -: EXP_W];
    assign eb   = b[W-2 -: EXP_W];
    assign fa   = a[MAN_W-1:0];
    assign fb   = b[MAN_W-1:0];
    assign za   = (ea == '0) & (fa == '0);
    assign zb   = (eb == '0) & (fb == '0);
    assign ia   = (&ea) & (fa == '0);
    assign ib   = (&eb) & (fb == '0);
    assign na   = (&ea) & (fa != '0);
    assign nb   = (&eb) & (fb != '0);
    // Subnormals: hidden bit 0, effective exponent 1.
    assign ma   = {ea != '0, fa};
    assign mb   = {eb != '0, fb};
    assign xa   = (ea == '0) ? EXP_W'(1) : ea;
    assign xb   = (eb == '0) ? EXP_W'(1) : eb;
    assign sgn  = a[W-1] ^ b[W-1];
    assign es   = $signed({2'b00, xa}) + $signed({2'b00, xb})
                - $signed(XW'(BIAS));
    assign prod = {{SW{1'b0}}, ma} * {{SW{1'b0}}, mb};

    always_comb begin
      sp_c = 1'b1;
      nv_c = 1'b0;
      sv_c = '0;
      if (na | nb | (ia & zb) | (za & ib)) begin
        nv_c = 1'b1;
        sv_c = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      end else if (ia | ib) begin
        sv_c = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (za | zb) begin
        sv_c = {sgn, {(W-1){1'b0}}};
      end else begin
        sp_c = 1'b0;
      end
    end

    logic [PW-1:0]        p1;
    logic signed [XW-1:0] e1;
    logic                 s1, sp1, nv1;
    logic [W-1:0]         sv1;

    always_ff @(posedge clk) begin
      if (adv) begin
        p1  <= prod;
        e1  <= es;
        s1  <= sgn;
        sp1 <= sp_c;
        nv1 <= nv_c;
        sv1 <= sv_c;
      end
    end

    logic [LW-1:0]        lz;
    logic [PW-1:0]        pn;
    logic signed [XW-1:0] en;

    always_comb begin
      lz = LW'(PW);
      for (int k = 0; k < PW; k++)
        if (p1[k]) lz = LW'(PW - 1 - k);
    end

    // e + 1 - lz covers both the MSB-set (+1) and the -(lz-1) cases.
    assign pn = p1 << lz;
    assign en = e1 + $signed(XW'(1)) - $signed(XW'(lz));

    logic [SW-1:0]        m2;
    logic                 g2, r2, t2, s2, sp2, nv2;
    logic signed [XW-1:0] e2;
    logic [W-1:0]         sv2;

    always_ff @(posedge clk) begin
      if (adv) begin
        m2  <= pn[PW-1 -: SW];
        g2  <= pn[PW-SW-1];
        r2  <= pn[PW-SW-2];
        t2  <= |pn[PW-SW-3:0];
        e2  <= en;
        s2  <= s1;
        sp2 <= sp1;
        nv2 <= nv1;
        sv2 <= sv1;
      end
    end

    logic [EW-1:0]        ext, sx, lostm;
    logic                 tiny, gg, rr, st, nx, of, uf, inc;
    logic [SW:0]          mr;
    logic signed [XW-1:0] ef;
    logic [W-1:0]         res;
    logic [3:0]           fl;
    int                   sh;

    always_comb begin
      ext   = {m2, g2, r2};
      tiny  = e2[XW-1] | (e2 == '0);
      sh    = 0;
      if (tiny) sh = 1 - int'(e2);
      if (sh > EW) sh = EW;
      lostm = ~({EW{1'b1}} << sh);
      sx    = ext >> sh;
      gg    = sx[1];
      rr    = sx[0];
      st    = t2 | (|(ext & lostm));
      nx    = gg | rr | st;
      inc   = (ROUND_MODE != 0) & gg & (rr | st | sx[2]);
      mr    = {1'b0, sx[EW-1:2]} + {{SW{1'b0}}, inc};
      // A carry into the hidden bit promotes a subnormal to exponent 1.
      if (tiny) ef = $signed(XW'(mr[MAN_W]));
      else      ef = e2 + $signed(XW'(mr[SW]));
      of    = !tiny & (ef >= $signed(XW'(EMAX)));
      uf    = tiny & !mr[MAN_W] & nx;
      res   = {s2, ef[EXP_W-1:0], mr[MAN_W-1:0]};
      if (of) begin
        nx  = 1'b1;
        res = (ROUND_MODE != 0)
            ? {s2, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
            : {s2, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
      end
      fl    = {1'b0, of, uf, nx};
      if (sp2) begin
        res = sv2;
        fl  = {nv2, 3'b000};
      end
    end

    logic [W-1:0] r_mul;
    logic [3:0]   r_fl;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_mul <= '0;
        r_fl  <= '0;
      end else if (adv) begin
        r_mul <= res;
        r_fl  <= fl;
      end
    end

    assign mul[i*W +: W]   = r_mul;
    assign flags[i*4 +: 4] = r_fl;
  end
endmodule

// File: tb/tb_bf_multiplier_pipe.sv
// tb_bf_multiplier_pipe: directed scoreboard bench for bf_multiplier_pipe,
// RNE and truncate instances side by side on the same stimulus.
module tb_bf_multiplier_pipe;
  localparam int L = 4;
  localparam int W = 16;

  typedef struct packed {
    logic [15:0] a, b, rm;
    logic [3:0]  rf;
    logic [15:0] tm;
    logic [3:0]  tf;
  } vec_t;

  typedef struct {
    logic [63:0] rm, tm;
    logic [15:0] rf, tf;
    int          stp;
    bit          lat;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b0;
  logic [L*W-1:0] num1 = '0;
  logic [L*W-1:0] num2 = '0;
  logic           in_ready, out_valid, in_ready_t, out_valid_t;
  logic [L*W-1:0] mul, mul_t;
  logic [L*4-1:0] flags, flags_t;

  vec_t        tbl [17];
  exp_t        sb [$];
  int          n_vec = 0;
  int          n_err = 0;
  int          step_no = 0;
  logic        stalled = 1'b0;
  logic [63:0] held_mul = '0;
  logic [15:0] held_fl = '0;

  bf_multiplier_pipe #(
    .EXP_W(8), .MAN_W(7), .LANES(L), .ROUND_MODE(1)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .num1(num1), .num2(num2),
    .out_valid(out_valid), .out_ready(out_ready),
    .mul(mul), .flags(flags)
  );

  bf_multiplier_pipe #(
    .EXP_W(8), .MAN_W(7), .LANES(L), .ROUND_MODE(0)
  ) dut_t (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready_t),
    .num1(num1), .num2(num2),
    .out_valid(out_valid_t), .out_ready(out_ready),
    .mul(mul_t), .flags(flags_t)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] want);
    n_vec++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s: got %h want %h (step %0d)", tag, obs, want, step_no);
    end
  endtask

  task automatic build(input int l0, l1, l2, l3, input bit lat,
                       output logic [63:0] n1, n2, output exp_t e);
    int ix [4];
    ix[0] = l0; ix[1] = l1; ix[2] = l2; ix[3] = l3;
    e.stp = 0;
    e.lat = lat;
    for (int l = 0; l < 4; l++) begin
      n1[l*16 +: 16]  = tbl[ix[l]].a;
      n2[l*16 +: 16]  = tbl[ix[l]].b;
      e.rm[l*16 +: 16] = tbl[ix[l]].rm;
      e.tm[l*16 +: 16] = tbl[ix[l]].tm;
      e.rf[l*4 +: 4]   = tbl[ix[l]].rf;
      e.tf[l*4 +: 4]   = tbl[ix[l]].tf;
    end
  endtask

  task automatic step(input logic v, input logic [63:0] n1, n2,
                      input logic ordy, input exp_t e, output logic acc);
    exp_t x;
    @(negedge clk);
    in_valid  = v;
    num1      = n1;
    num2      = n2;
    out_ready = ordy;
    #1;
    step_no++;
    chk("in_ready", 64'(in_ready), 64'(!out_valid | out_ready));
    chk("in_ready_t", 64'(in_ready_t), 64'(!out_valid | out_ready));
    chk("valid_t", 64'(out_valid_t), 64'(out_valid));
    if (stalled) begin
      chk("hold_mul", mul, held_mul);
      chk("hold_flags", 64'(flags), 64'(held_fl));
    end
    if (out_valid && out_ready) begin
      n_vec++;
      assert (sb.size() > 0) else begin
        n_err++;
        $error("FAIL stale: got out_valid 1 want no beat (step %0d)",
               step_no);
      end
      if (sb.size() > 0) begin
        x = sb.pop_front();
        chk("mul_rne", mul, x.rm);
        chk("flags_rne", 64'(flags), 64'(x.rf));
        chk("mul_trunc", mul_t, x.tm);
        chk("flags_trunc", 64'(flags_t), 64'(x.tf));
        if (x.lat) chk("latency", 64'(step_no - x.stp), 64'd3);
      end
    end
    acc = v && in_ready;
    if (acc) begin
      x = e;
      x.stp = step_no;
      sb.push_back(x);
    end
    stalled  = out_valid && !out_ready;
    held_mul = mul;
    held_fl  = flags;
  endtask

  task automatic send(input int l0, l1, l2, l3, input bit lat,
                      input bit rnd);
    logic [63:0] n1, n2;
    exp_t        e;
    logic        acc;
    int          tries;
    build(l0, l1, l2, l3, lat, n1, n2, e);
    acc   = 1'b0;
    tries = 0;
    while (!acc && tries < 20) begin
      step(1'b1, n1, n2, rnd ? 1'($urandom_range(0, 1)) : 1'b1, e, acc);
      tries++;
    end
    n_vec++;
    assert (acc) else begin
      n_err++;
      $error("FAIL accept: got in_ready 0 for 20 cycles want 1");
    end
  endtask

  task automatic drain(input int budget, input bit rnd);
    logic acc;
    exp_t z;
    z.rm = '0; z.tm = '0; z.rf = '0; z.tf = '0; z.stp = 0; z.lat = 1'b0;
    for (int k = 0; k < budget && (sb.size() > 0 || out_valid); k++)
      step(1'b0, '0, '0, rnd ? 1'($urandom_range(0, 1)) : 1'b1, z, acc);
    n_vec++;
    assert (sb.size() == 0) else begin
      n_err++;
      $error("FAIL drain: got %0d beats outstanding want 0", sb.size());
    end
  endtask

  initial begin
    logic acc;
    exp_t z;
    z.rm = '0; z.tm = '0; z.rf = '0; z.tf = '0; z.stp = 0; z.lat = 1'b0;
    //           a        b        rne      rf    trunc    tf
    tbl[0]  = '{16'h3FC0, 16'h3FC0, 16'h4010, 4'h0, 16'h4010, 4'h0};
    tbl[1]  = '{16'h3F80, 16'hC000, 16'hC000, 4'h0, 16'hC000, 4'h0};
    tbl[2]  = '{16'h3F81, 16'h3FC0, 16'h3FC2, 4'h1, 16'h3FC1, 4'h1};
    tbl[3]  = '{16'h7F00, 16'h4000, 16'h7F80, 4'h5, 16'h7F7F, 4'h5};
    tbl[4]  = '{16'h0080, 16'h3F00, 16'h0040, 4'h0, 16'h0040, 4'h0};
    tbl[5]  = '{16'h7F80, 16'h0000, 16'h7FC0, 4'h8, 16'h7FC0, 4'h8};
    tbl[6]  = '{16'hFF80, 16'h4000, 16'hFF80, 4'h0, 16'hFF80, 4'h0};
    tbl[7]  = '{16'h0001, 16'h3F00, 16'h0000, 4'h3, 16'h0000, 4'h3};
    tbl[8]  = '{16'h007F, 16'h3F81, 16'h0080, 4'h1, 16'h007F, 4'h3};
    tbl[9]  = '{16'h8000, 16'h3F80, 16'h8000, 4'h0, 16'h8000, 4'h0};
    tbl[10] = '{16'h7F80, 16'hBF80, 16'hFF80, 4'h0, 16'hFF80, 4'h0};
    tbl[11] = '{16'hFFC1, 16'h3F80, 16'h7FC0, 4'h8, 16'h7FC0, 4'h8};
    tbl[12] = '{16'hFF80, 16'h8000, 16'h7FC0, 4'h8, 16'h7FC0, 4'h8};
    tbl[13] = '{16'h3F81, 16'h3F81, 16'h3F82, 4'h1, 16'h3F82, 4'h1};
    tbl[14] = '{16'h3FC1, 16'h3FC1, 16'h4012, 4'h1, 16'h4011, 4'h1};
    tbl[15] = '{16'hFF00, 16'h4000, 16'hFF80, 4'h5, 16'hFF7F, 4'h5};
    tbl[16] = '{16'h7F7F, 16'h3F80, 16'h7F7F, 4'h0, 16'h7F7F, 4'h0};

    #1 rst = 1'b1;
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_mul", mul, 64'd0);
    chk("rst_flags", 64'(flags), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_mul_t", mul_t, 64'd0);
    @(negedge clk);
    #2 rst = 1'b0;

    // Back-to-back with out_ready high: each beat has 3-cycle latency.
    send(0, 1, 2, 3, 1'b1, 1'b0);
    send(4, 5, 6, 7, 1'b1, 1'b0);
    send(8, 9, 10, 11, 1'b1, 1'b0);
    send(12, 13, 14, 15, 1'b1, 1'b0);
    send(16, 3, 7, 8, 1'b1, 1'b0);
    drain(10, 1'b0);

    // Backpressure: pseudo-random out_ready, mixed lanes per beat.
    for (int bt = 0; bt < 8; bt++)
      send((bt*5) % 17, (bt*5+3) % 17, (bt*5+6) % 17, (bt*5+9) % 17,
           1'b0, 1'b1);
    drain(60, 1'b1);

    // Reset while three beats are in flight and the output is stalled.
    send(0, 2, 4, 6, 1'b0, 1'b0);
    send(1, 3, 5, 7, 1'b0, 1'b0);
    send(8, 10, 12, 14, 1'b0, 1'b0);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_valid_t", 64'(out_valid_t), 64'd0);
    chk("mid_rst_mul", mul, 64'd0);
    chk("mid_rst_flags", 64'(flags), 64'd0);
    chk("mid_rst_ready", 64'(in_ready), 64'd1);
    sb.delete();
    stalled = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (6) step(1'b0, '0, '0, 1'b1, z, acc);
    send(13, 14, 15, 16, 1'b1, 1'b0);
    drain(10, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
